// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART transmit path. uart_send and
// uart_tx_arbiter both take their bit timing from DEFAULT_BIT_CYCLES, so the
// launch pacing and the serialiser stay in step.
//
// Contents:
//   FRAME_BITS          start + 8 data + stop bits per frame
//   DEFAULT_BIT_CYCLES  clock cycles per bit (100 MHz / 9600 baud)
//   tx_state_t          arbiter FSM state (IDLE, BUSY)
//   slot_cycles()       cycles from one launch to the earliest next launch
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int FRAME_BITS         = 10;
    localparam int DEFAULT_BIT_CYCLES = 10417;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } tx_state_t;

    // One frame plus the idle gap that follows it, in clock cycles.
    function automatic int slot_cycles(input int bit_cycles, input int gap_bits);
        return (FRAME_BITS + gap_bits) * bit_cycles;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational masked round-robin picker. Requests strictly above the
// pointer are tried first; if none, the lowest request overall wins, which is
// the wrap-around. When lock_en is set only lock_idx can be granted.
//
// Ports:
//   req        in  NUM_REQ  request vector
//   ptr        in  IDX_W    index of the previous winner
//   lock_en    in  1        restrict the grant to lock_idx
//   lock_idx   in  IDX_W    the locked requester
//   grant      out NUM_REQ  one-hot grant, or zero when nothing is eligible
//   grant_idx  out IDX_W    index of the granted requester
// -----------------------------------------------------------------------------
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               lock_en,
    input  logic [IDX_W-1:0]   lock_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [NUM_REQ-1:0] masked;
    logic [IDX_W-1:0]   masked_idx;
    logic [IDX_W-1:0]   plain_idx;

    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        masked     = '0;
        masked_idx = '0;
        plain_idx  = '0;
        grant      = '0;
        grant_idx  = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req[i] && (i > int'(ptr));
        end

        // Scan downward so the lowest set bit is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) masked_idx = IDX_W'(i);
            if (req[i])    plain_idx  = IDX_W'(i);
        end

        if (lock_en) begin
            grant_idx        = lock_idx;
            grant[lock_idx]  = req[lock_idx];
        end else if (|masked) begin
            grant_idx          = masked_idx;
            grant[masked_idx]  = 1'b1;
        end else if (|req) begin
            grant_idx         = plain_idx;
            grant[plain_idx]  = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_send transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration, with the grant locked to one requester until it
// presents a byte with req_last. Each accepted byte produces one single-cycle
// tx_valid pulse; the next launch is held off for a full frame plus gap.
//
// Parameters:
//   NUM_REQ     requesters, 2..8
//   BIT_CYCLES  clock cycles per UART bit
//   GAP_BITS    idle bit-times after each frame, 0..15
//
// Ports:
//   clk        in  1          rising-edge clock
//   rst_n      in  1          asynchronous active-low reset
//   req_valid  in  NUM_REQ    requester i has a byte
//   req_data   in  8*NUM_REQ  byte of requester i in [8i+7:8i]
//   req_last   in  NUM_REQ    byte ends requester i's message
//   req_ready  out NUM_REQ    one-hot or zero; accept on valid & ready
//   tx_valid   out 1          one-cycle launch pulse to uart_send
//   tx_data    out 8          launched byte, held until the next launch
//   busy       out 1          frame or gap in progress
//   grant_id   out IDX_W      last accepted requester
//   locked     out 1          grant locked mid-message
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter int GAP_BITS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SLOT  = slot_cycles(BIT_CYCLES, GAP_BITS);
    localparam int TMR_W = $clog2(SLOT);

    tx_state_t            state;
    tx_state_t            next_state;
    logic [TMR_W-1:0]     timer;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 accept;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .lock_en   (locked),
        .lock_idx  (grant_id),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // The picker only grants valid requesters, so any grant in IDLE is an
    // accepted byte.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = pick_grant;
                accept    = |pick_grant;
                if (accept) next_state = BUSY;
            end
            BUSY: begin
                if (timer == '0) next_state = IDLE;
            end
        endcase
    end

    // The timer is loaded with SLOT-2 so BUSY covers launch cycles T+1 ..
    // T+SLOT-1 and the next acceptance can land exactly SLOT cycles later.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            grant_id <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= next_state;
            tx_valid <= accept;
            if (accept) begin
                tx_data  <= req_data[8*pick_idx +: 8];
                rr_ptr   <= pick_idx;
                grant_id <= pick_idx;
                locked   <= !req_last[pick_idx];
                timer    <= TMR_W'(SLOT - 2);
            end else if (state == BUSY && timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter with NUM_REQ=3, BIT_CYCLES=4.
// The main instance uses GAP_BITS=1 (SLOT=44); a second instance uses
// GAP_BITS=0 (SLOT=40) for the gap boundary. The reference model tracks the
// arbiter as "cycles since the last launch", a round-robin pointer and a lock
// owner, and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ  = 3;
    localparam int BITC  = 4;
    localparam int SLOT  = 44;
    localparam int SLOT0 = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid, req_last, req_ready;
    logic [23:0] req_data;
    logic        tx_valid, busy, locked;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;

    logic [2:0]  g_valid, g_last, g_ready;
    logic [23:0] g_data;
    logic        g_tx_valid, g_busy, g_locked;
    logic [7:0]  g_tx_data;
    logic [1:0]  g_grant_id;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model state.
    int         m_ptr, m_gid, m_since, m_acc_id;
    logic       m_locked, m_tx_valid;
    logic [7:0] m_tx_data;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .BIT_CYCLES(BITC), .GAP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .busy(busy), .grant_id(grant_id), .locked(locked)
    );

    uart_tx_arbiter #(.NUM_REQ(NREQ), .BIT_CYCLES(BITC), .GAP_BITS(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .req_valid(g_valid), .req_data(g_data),
        .req_last(g_last), .req_ready(g_ready), .tx_valid(g_tx_valid),
        .tx_data(g_tx_data), .busy(g_busy), .grant_id(g_grant_id), .locked(g_locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_ptr      = NREQ - 1;
        m_gid      = 0;
        m_since    = SLOT;
        m_acc_id   = -1;
        m_locked   = 1'b0;
        m_tx_valid = 1'b0;
        m_tx_data  = 8'h00;
    endfunction

    function automatic logic [2:0] exp_ready();
        logic [2:0] r;
        int idx;
        r = '0;
        if (m_since < SLOT) return r;
        if (m_locked) begin
            r[m_gid] = req_valid[m_gid];
            return r;
        end
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (req_valid[idx]) begin
                r[idx] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic void model_step();
        logic [2:0] r;
        int w;
        r = exp_ready();
        w = -1;
        for (int i = 0; i < NREQ; i++) if (r[i]) w = i;
        m_acc_id = w;
        if (w >= 0) begin
            m_tx_valid = 1'b1;
            m_tx_data  = req_data[8*w +: 8];
            m_ptr      = w;
            m_gid      = w;
            m_locked   = !req_last[w];
            m_since    = 1;
        end else begin
            m_tx_valid = 1'b0;
            if (m_since < SLOT) m_since++;
        end
    endfunction

    function automatic logic [15:0] exp_vec();
        return {exp_ready(), m_tx_valid, m_tx_data, (m_since < SLOT), 2'(m_gid), m_locked};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {req_ready, tx_valid, tx_data, busy, grant_id, locked};
    endfunction

    // Advance one clock; inputs change at posedge+1, comparisons at posedge+2.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        g_valid   = '0; g_last   = '0; g_data   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int pulses, busy_cnt;
        do_reset();
        vectors++;
        if (dut_vec() !== 16'h0000)
            begin miscompares++; $display("FAIL reset_values: got %h expected 0000 {ready,txv,data,busy,gid,lock}", dut_vec()); end
        req_valid = 3'b001;
        req_data  = {16'($urandom), 8'h32};
        req_last  = 3'b001;
        pulses = 0; busy_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (c == 1) req_valid = 3'b000;
            #1;
            vectors++;
            if (dut_vec() !== exp_vec())
                begin miscompares++; $display("FAIL reset_first c=%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
            if (c == 0) begin
                vectors++;
                if (req_ready !== 3'b001)
                    begin miscompares++; $display("FAIL first_ready: got %b expected 001", req_ready); end
            end
            if (tx_valid === 1'b1) begin
                pulses++;
                vectors++;
                if (tx_data !== 8'h32)
                    begin miscompares++; $display("FAIL first_data: got %h expected 32", tx_data); end
            end
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
        vectors++;
        if (pulses != 1) begin miscompares++; $display("FAIL first_pulses: got %0d expected 1", pulses); end
        vectors++;
        if (busy_cnt != SLOT - 1) begin miscompares++; $display("FAIL busy_len: got %0d expected %0d", busy_cnt, SLOT - 1); end
    endtask

    task automatic test_round_robin();
        int exp_gid [5] = '{0, 1, 2, 0, 1};
        int n, last_launch;
        do_reset();
        req_valid = 3'b111;
        req_last  = 3'b111;
        n = 0; last_launch = 0;
        for (int c = 0; c < 4*SLOT + 5; c++) begin
            req_data = 24'($urandom);
            #1;
            vectors++;
            if (dut_vec() !== exp_vec())
                begin miscompares++; $display("FAIL rr c=%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
            if (tx_valid === 1'b1 && n < 5) begin
                vectors++;
                if (grant_id !== 2'(exp_gid[n]))
                    begin miscompares++; $display("FAIL rr_order launch %0d: got %0d expected %0d", n, grant_id, exp_gid[n]); end
                if (n > 0) begin
                    vectors++;
                    if (cyc - last_launch != SLOT)
                        begin miscompares++; $display("FAIL rr_spacing: got %0d expected %0d", cyc - last_launch, SLOT); end
                end
                last_launch = cyc;
                n++;
            end
            tick();
        end
        vectors++;
        if (n < 4) begin miscompares++; $display("FAIL rr_count: got %0d launches expected >= 4", n); end
    endtask

    task automatic test_lock();
        logic [7:0] bytes [3] = '{8'h30, 8'h32, 8'h33};
        logic [7:0] exp_data [4] = '{8'h30, 8'h32, 8'h33, 8'h55};
        int exp_gid [4] = '{1, 1, 1, 0};
        int k, n;
        do_reset();
        k = 0; n = 0;
        for (int c = 0; c < 4*SLOT + 10; c++) begin
            if (m_acc_id == 1) k++;
            req_valid[0] = (k >= 1);
            req_data[7:0] = 8'h55;
            req_last[0]   = 1'b1;
            req_data[23:16] = 8'($urandom);
            req_valid[2] = 1'b0;
            req_last[2]  = 1'b1;
            if (k < 3) begin
                req_valid[1]   = 1'b1;
                req_data[15:8] = bytes[k];
                req_last[1]    = (k == 2);
            end else begin
                req_valid[1] = 1'b0;
                req_last[1]  = 1'b0;
            end
            #1;
            vectors++;
            if (dut_vec() !== exp_vec())
                begin miscompares++; $display("FAIL lock c=%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
            if (tx_valid === 1'b1 && n < 4) begin
                vectors++;
                if ({grant_id, tx_data, locked} !== {2'(exp_gid[n]), exp_data[n], (n < 2)})
                    begin miscompares++; $display("FAIL lock_launch %0d: got gid=%0d data=%h lock=%b expected gid=%0d data=%h lock=%b",
                                                  n, grant_id, tx_data, locked, exp_gid[n], exp_data[n], (n < 2)); end
                n++;
            end
            tick();
        end
        vectors++;
        if (n < 4) begin miscompares++; $display("FAIL lock_count: got %0d launches expected 4", n); end
    endtask

    task automatic test_valid_drop();
        int extra;
        do_reset();
        req_data = 24'($urandom);
        req_last = 3'b111;
        extra = 0;
        for (int c = 0; c < SLOT + 20; c++) begin
            req_valid = (c == 0) ? 3'b001 : ((c == 10) ? 3'b100 : 3'b000);
            #1;
            vectors++;
            if (dut_vec() !== exp_vec())
                begin miscompares++; $display("FAIL drop c=%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
            if (c == 10) begin
                vectors++;
                if (req_ready !== 3'b000)
                    begin miscompares++; $display("FAIL drop_ready: got %b expected 000", req_ready); end
            end
            if (c >= 2 && tx_valid === 1'b1) extra++;
            tick();
        end
        vectors++;
        if (extra != 0) begin miscompares++; $display("FAIL drop_launch: got %0d extra launches expected 0", extra); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        req_valid = 3'b010;
        req_last  = 3'b000;
        for (int c = 0; c < 20; c++) begin
            req_data = 24'($urandom);
            #1;
            vectors++;
            if (dut_vec() !== exp_vec())
                begin miscompares++; $display("FAIL midrst_pre c=%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
            tick();
        end
        rst_n = 1'b0;
        req_valid = '0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if (dut_vec() !== 16'h0000)
                begin miscompares++; $display("FAIL midrst_values: got %h expected 0000", dut_vec()); end
            vectors++;
            if (locked !== 1'b0)
                begin miscompares++; $display("FAIL midrst_lock: got %b expected 0", locked); end
            tick();
        end
        rst_n     = 1'b1;
        req_valid = 3'b011;
        req_last  = 3'b011;
        #1;
        vectors++;
        if (req_ready !== 3'b001)
            begin miscompares++; $display("FAIL midrst_ready: got %b expected 001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        vectors++;
        if ({tx_valid, grant_id} !== {1'b1, 2'd0})
            begin miscompares++; $display("FAIL midrst_grant: got txv=%b gid=%0d expected txv=1 gid=0", tx_valid, grant_id); end
    endtask

    task automatic test_gap_boundary();
        int last_acc, n;
        do_reset();
        g_valid = 3'b111;
        g_last  = 3'b111;
        last_acc = -1; n = 0;
        for (int c = 0; c < 3*SLOT0 + 5; c++) begin
            g_data = 24'($urandom);
            #1;
            if (last_acc >= 0 && cyc - last_acc == 1) begin
                vectors++;
                if (g_tx_valid !== 1'b1)
                    begin miscompares++; $display("FAIL gap_txv: got %b expected 1", g_tx_valid); end
            end
            if (last_acc >= 0 && cyc - last_acc == SLOT0 - 1) begin
                vectors++;
                if (g_ready !== 3'b000)
                    begin miscompares++; $display("FAIL gap_ready39: got %b expected 000", g_ready); end
            end
            if (g_ready !== 3'b000) begin
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc != SLOT0)
                        begin miscompares++; $display("FAIL gap_spacing: got %0d expected %0d", cyc - last_acc, SLOT0); end
                end
                last_acc = cyc;
                n++;
            end
            tick();
        end
        vectors++;
        if (n < 3) begin miscompares++; $display("FAIL gap_count: got %0d accepts expected >= 3", n); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        g_valid = '0; g_last = '0; g_data = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_lock();
        test_valid_drop();
        test_reset_mid_frame();
        test_gap_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
